// File: rtl/matmult_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier.
package matmult_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Result width: two W-bit operands plus headroom for summing N products.
  function automatic int matmult_ow(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/matmult_if.sv
// Element input stream and result output stream of the matrix multiplier.
interface matmult_if
  import matmult_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 2
) ();

  localparam int OW = matmult_ow(N, W);

  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/matmult_mac.sv
// Registered multiply-accumulate with clear-on-first; MATMULT_SIGNED_EN selects
// two's-complement operands, otherwise operands are unsigned.
module matmult_mac #(
  parameter int W  = 2,
  parameter int OW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          first,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [OW-1:0] sum
);

`ifdef MATMULT_SIGNED_EN
  function automatic logic signed [OW-1:0] ext_op(input logic [W-1:0] v);
    return {{(OW-W){v[W-1]}}, v};
  endfunction

  logic signed [OW-1:0] a_ext;
  logic signed [OW-1:0] b_ext;
  logic signed [OW-1:0] prod;
  logic signed [OW-1:0] base;
  logic signed [OW-1:0] sum_s;
  logic signed [OW-1:0] acc_d;
  logic signed [OW-1:0] acc_q;
`else
  function automatic logic [OW-1:0] ext_op(input logic [W-1:0] v);
    return {{(OW-W){1'b0}}, v};
  endfunction

  logic [OW-1:0] a_ext;
  logic [OW-1:0] b_ext;
  logic [OW-1:0] prod;
  logic [OW-1:0] base;
  logic [OW-1:0] sum_s;
  logic [OW-1:0] acc_d;
  logic [OW-1:0] acc_q;
`endif

  // The true sum always fits in OW bits, so keeping the low OW bits of the
  // product is exact in both signed and unsigned modes.
  always_comb begin
    a_ext = ext_op(a);
    b_ext = ext_op(b);
    prod  = a_ext * b_ext;
    base  = first ? '0 : acc_q;
    sum_s = base + prod;
    acc_d = en ? sum_s : acc_q;
  end

  assign sum = sum_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN matrix multiplier: stream in A then B, compute C = A*B on one
// shared MAC, stream out C row-major. MATMULT_SIGNED_EN enables signed elements.
module matrix_mult_seq
  import matmult_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 2
) (
  input  logic       clk,
  input  logic       reset,
  matmult_if.slave   bus,
  output logic       busy
);

  localparam int OW     = matmult_ow(N, W);
  localparam int NN     = N * N;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ADDR_W = (NN > 1) ? $clog2(NN) : 1;
  localparam int LD_W   = $clog2(2 * NN);

  localparam logic [LD_W-1:0]  LD_LAST   = LD_W'(2 * NN - 1);
  localparam logic [LD_W-1:0]  LD_B_BASE = LD_W'(NN);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

  state_e          state_q, state_d;
  logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [OW-1:0]   out_data_q, out_data_d;

  logic [W-1:0] a_mem_q [NN];
  logic [W-1:0] a_mem_d [NN];
  logic [W-1:0] b_mem_q [NN];
  logic [W-1:0] b_mem_d [NN];

  logic              in_ready;
  logic              in_hs;
  logic              mac_en;
  logic              mac_first;
  logic [OW-1:0]     mac_sum;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] ld_addr;
  logic [LD_W-1:0]   ld_off;
  logic              at_last_ij;

  // in_ready is gated by reset so nothing is accepted while reset is held.
  assign in_ready   = (state_q == LOAD) && !reset;
  assign in_hs      = bus.in_valid && in_ready;
  assign at_last_ij = (i_q == IDX_LAST) && (j_q == IDX_LAST);

  assign a_addr  = ADDR_W'(ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q));
  assign b_addr  = ADDR_W'(ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q));
  assign ld_off  = ld_cnt_q - LD_B_BASE;
  assign ld_addr = (ld_cnt_q < LD_B_BASE) ? ADDR_W'(ld_cnt_q) : ADDR_W'(ld_off);

  matmult_mac #(
    .W  (W),
    .OW (OW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .first (mac_first),
    .a     (a_mem_q[a_addr]),
    .b     (b_mem_q[b_addr]),
    .sum   (mac_sum)
  );

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    a_mem_d    = a_mem_q;
    b_mem_d    = b_mem_q;
    mac_en     = 1'b0;
    mac_first  = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (ld_cnt_q < LD_B_BASE) begin
            a_mem_d[ld_addr] = bus.in_data;
          end else begin
            b_mem_d[ld_addr] = bus.in_data;
          end
          if (ld_cnt_q == LD_LAST) begin
            ld_cnt_d = '0;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            state_d  = COMPUTE;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
          end
        end
      end

      COMPUTE: begin
        mac_en    = 1'b1;
        mac_first = (k_q == '0);
        if (k_q == IDX_LAST) begin
          k_d        = '0;
          out_data_d = mac_sum;
          state_d    = OUTPUT;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end

      OUTPUT: begin
        if (bus.out_ready) begin
          if (at_last_ij) begin
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            ld_cnt_d = '0;
            state_d  = LOAD;
          end else begin
            if (j_q == IDX_LAST) begin
              j_d = '0;
              i_d = i_q + IDX_W'(1);
            end else begin
              j_d = j_q + IDX_W'(1);
            end
            state_d = COMPUTE;
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      ld_cnt_q   <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
    end
  end

  // Matrix storage is never cleared; every element is rewritten by the next load.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = (state_q == OUTPUT) && at_last_ij;
  assign busy          = (state_q != LOAD);

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Randomized self-checking bench for matrix_mult_seq against a plain C = A*B model.
module tb_matrix_mult_seq;

  localparam int N  = 2;
  localparam int W  = 2;
  localparam int NN = N * N;
  localparam int OW = 2 * W + $clog2(N);

  logic clk = 1'b0;
  logic reset;
  logic busy;

  matmult_if #(.N(N), .W(W)) bus ();

  matrix_mult_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ma [NN];
  int mb [NN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int elem_val(input int code);
`ifdef MATMULT_SIGNED_EN
    return (code >= (1 << (W - 1))) ? code - (1 << W) : code;
`else
    return code;
`endif
  endfunction

  // Reference result C[r/N][r%N], truncated to the OW-bit output bus.
  function automatic int ref_c(input int r);
    int i, j, s;
    i = r / N;
    j = r % N;
    s = 0;
    for (int k = 0; k < N; k++) s += elem_val(ma[i*N+k]) * elem_val(mb[k*N+j]);
    return s & ((1 << OW) - 1);
  endfunction

  task automatic set_case1();
    ma = '{1, 2, 3, 0};
    mb = '{2, 1, 0, 3};
  endtask

  task automatic set_const(input int v);
    for (int e = 0; e < NN; e++) begin
      ma[e] = v;
      mb[e] = v;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready_held", bus.in_ready, 0);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_release", bus.in_ready, 1);
  endtask

  task automatic load_all(input bit gaps, input int stop_after);
    int code;
    for (int e = 0; e < 2 * NN; e++) begin
      if (e == stop_after) return;
      code = (e < NN) ? ma[e] : mb[e-NN];
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          bus.in_valid = 1'b0;
          bus.in_data  = W'($urandom);
          @(negedge clk);
        end
      end
      chk("load_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(code);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic collect(input bit bp_first, input bit rand_bp);
    int lat, hold;
    logic [OW-1:0] d0;
    for (int r = 0; r < NN; r++) begin
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
        lat++;
        @(negedge clk);
      end
      chk("result_latency", lat, N);
      if (lat >= 50) return;
      hold = (bp_first && r == 0) ? 10 : (rand_bp ? $urandom_range(0, 3) : 0);
      d0 = bus.out_data;
      for (int h = 0; h < hold; h++) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'($urandom);
        @(negedge clk);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_data_stable", bus.out_data, d0);
        chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      chk("out_data", bus.out_data, ref_c(r));
      chk("out_last", bus.out_last, (r == NN - 1) ? 1 : 0);
      chk("busy_output", busy, 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    chk("done_busy", busy, 0);
    chk("done_out_valid", bus.out_valid, 0);
    chk("done_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_case(input bit gaps, input bit bp_first, input bit rand_bp);
    load_all(gaps, 2 * NN);
    chk("compute_in_ready", bus.in_ready, 0);
    chk("compute_busy", busy, 1);
    collect(bp_first, rand_bp);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    pulse_reset();

    set_case1();
    run_case(1'b0, 1'b0, 1'b0);

    set_const(3);
    run_case(1'b0, 1'b0, 1'b0);

    set_const(2);
    run_case(1'b0, 1'b0, 1'b0);

    set_case1();
    run_case(1'b0, 1'b1, 1'b0);

    set_case1();
    run_case(1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int e = 0; e < NN; e++) begin
        ma[e] = $urandom_range(0, (1 << W) - 1);
        mb[e] = $urandom_range(0, (1 << W) - 1);
      end
      run_case(1'b1, 1'b0, 1'b1);
    end

    // Abort a partial load, then a clean load must give fresh results.
    set_const(3);
    load_all(1'b0, 5);
    pulse_reset();
    set_case1();
    run_case(1'b0, 1'b0, 1'b0);

    // Abort while a result is pending.
    set_const(1);
    load_all(1'b0, 2 * NN);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("pending_valid", bus.out_valid, 1);
    pulse_reset();
    set_case1();
    run_case(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mult_seq.md
# matrix_mult_seq

Parametrised sequential N×N matrix multiplier and the successor to the fixed-size combinational matrix multiplier. It loads two N×N matrices element by element over a narrow valid/ready input stream. It computes C = A·B with one shared multiply-accumulate unit, one product per cycle, and streams the N² results out over a valid/ready output with backpressure. It sits behind the top-level pin wrapper, where dedicated inputs feed the input stream and dedicated/bidirectional outputs carry the results.

## Interface
- N, 2, matrix dimension (N ≥ 1)
- W, 2, element width in bits
- OW (localparam), 2*W + $clog2(N), result width; overflow is impossible
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- in_data  input  W  element being loaded
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts an element this cycle
- out_data  output  OW  result element C[i][j]
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the result
- out_last  output  1  asserted together with out_valid for C[N-1][N-1]
- busy  output  1  block is in the COMPUTE or OUTPUT state

## Operation
- States: LOAD, COMPUTE, OUTPUT.
- LOAD
  - in_ready = 1.
  - Each handshake (in_valid & in_ready) writes the next element: 2·N² elements total, A row-major, then B row-major.
  - Gaps with in_valid = 0 are allowed; the load counter holds during gaps.
  - The handshake that delivers B[N-1][N-1] moves the state to COMPUTE with i = j = k = 0.
- COMPUTE
  - in_ready = 0.
  - Each cycle: acc ← (k==0 ? 0 : acc) + A[i][k]·B[k][j], then k++.
  - On k = N-1, the final sum is registered into out_data and the state moves to OUTPUT.
- OUTPUT
  - out_valid = 1; out_data and out_last are held stable until out_ready.
  - On handshake with (i,j) = (N-1,N-1): go to LOAD and clear all counters.
  - Otherwise: advance j, wrapping j to 0 and incrementing i; then go to COMPUTE.
- Arithmetic: operands are zero-extended to OW bits before the multiply. The sum of N products of two W-bit values always fits in OW bits.
- in_valid outside LOAD is ignored and no data is consumed.
- Matrix storage is not cleared between operations; every element is rewritten by the next LOAD.

## Timing
- Reset (synchronous, sampled on the clk edge):
  - state = LOAD, all counters = 0, acc = 0.
  - Outputs: out_data = 0, out_valid = 0, out_last = 0, busy = 0.
  - in_ready = 0 while reset is high and 1 in the first cycle after release.
- Reset asserted mid-operation, in any state, aborts the operation. Any partially loaded data or pending result is discarded. out_valid drops on the next edge.
- First result: if the last B element is accepted at edge t, COMPUTE runs at edges t+1 … t+N and out_valid = 1 after edge t+N.
- Later results: if the output handshake occurs at edge u, the next out_valid = 1 after edge u+N.
- Result spacing: N cycles per result plus one handshake cycle; zero bubble is added when out_ready is held high.
- A new LOAD can accept its first element in the cycle after the final output handshake.
- Holding out_ready = 0 stalls indefinitely with no data loss.

## Configuration
- MATMULT_SIGNED_EN
  - Defined: elements are two's-complement. Operands are sign-extended to OW bits and the products are signed, so out_data is a signed OW-bit value.
  - Undefined: unsigned arithmetic as described above.
- OW is the same in both modes; the worst signed case, N·2^(2W-2), fits.

## Structure
- Package matmult_pkg holds:
  - the state enum (LOAD, COMPUTE, OUTPUT);
  - the function matmult_ow(N, W) returning OW.
- Sub-module matmult_mac: a registered multiply-accumulate with a clear-on-first input and the signed/unsigned selection under MATMULT_SIGNED_EN.
- The top level holds the matrix register files, the index counters and the FSM.

## Test plan
- Unsigned, N=2, W=2: A = [[1,2],[3,0]], B = [[2,1],[0,3]], out_ready = 1 → outputs 2, 7, 6, 3 in order; out_last is set on 3; busy then drops.
- Unsigned saturation: all elements = 3 → four outputs of 18; out_valid first rises N cycles after the last input is accepted.
- MATMULT_SIGNED_EN, all elements = 2'b10 (−2) → four outputs of +8; A = −1·I and B = [[1,1],[1,1]] → all outputs = −1 (5'b11111).
- Backpressure: hold out_ready = 0 for 10 cycles on the first result → out_data = 2 stays stable and no extra input is accepted; release → the remaining sequence is unchanged.
- Input gaps: toggle in_valid randomly during LOAD → same results as the gapless load.
- Reset after 5 loaded elements, then a full clean load of the first test case → outputs 2, 7, 6, 3 with no stale-data effect.
